// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration-time helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        STAGED  = 2'd2,
        RUN     = 2'd3
    } seq_state_e;

    // Edge (relative to t = 0) after which o_rst[k] reads low.
    function automatic int rel_time(input int k, input int stretch, input int gap);
        return stretch + k * gap;
    endfunction

    // Counter must hold up to last release time + 1 without wrapping.
    function automatic int cnt_width(input int stages, input int stretch, input int gap);
        return $clog2(stretch + (stages - 1) * gap + 2);
    endfunction

endpackage

// File: rtl/rst_seq_heartbeat.sv
// Heartbeat divider: toggles the LED every HB_DIV enabled cycles.
module rst_seq_heartbeat
#(
    parameter int HB_DIV = 50000000
)
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_led
);

    localparam int DW = (HB_DIV > 2) ? $clog2(HB_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(HB_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          led_q, led_d;

    // Next divider/LED value; clear wins over counting.
    always_comb begin
        div_d = div_q;
        led_d = led_q;
        if (i_clr) begin
            div_d = '0;
            led_d = 1'b0;
        end else if (i_en) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                led_d = ~led_q;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Divider and LED registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_q <= '0;
            led_q <= 1'b0;
        end else begin
            div_q <= div_d;
            led_q <= led_d;
        end
    end

    assign o_led = led_q;

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release: stretch after reset, then free stages in ascending
// order one gap apart, then flag ready and run the heartbeat.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int STAGES         = 3,
    parameter int STRETCH_CYCLES = 1024,
    parameter int STAGE_GAP      = 16,
    parameter int HB_DIV         = 50000000
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_soft_rst,
    output logic [STAGES-1:0] o_rst,
    output logic              o_ready,
    output logic              o_led
);

    localparam int CW = cnt_width(STAGES, STRETCH_CYCLES, STAGE_GAP);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    // The counter lags t by one, so each threshold is the release edge - 1.
    localparam logic [CW-1:0] REL0_M1  = CW'(rel_time(0, STRETCH_CYCLES, STAGE_GAP) - 1);
    localparam logic [CW-1:0] LAST_REL = CW'(rel_time(STAGES - 1, STRETCH_CYCLES, STAGE_GAP));

    seq_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [STAGES-1:0] rst_q, rst_d;
    logic              rdy_q, rdy_d;

    // Next-state, counter and stage-release logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        rdy_d   = rdy_q;
        case (state_q)
            HOLD: begin
                cnt_d   = '0;
                rst_d   = '1;
                rdy_d   = 1'b0;
                state_d = STRETCH;
            end
            STRETCH, STAGED: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                for (int k = 0; k < STAGES; k++) begin
                    if (cnt_q >= CW'(rel_time(k, STRETCH_CYCLES, STAGE_GAP) - 1))
                        rst_d[k] = 1'b0;
                end
                if (state_q == STRETCH) begin
                    if (cnt_q >= REL0_M1) state_d = STAGED;
                end else if (cnt_q >= LAST_REL) begin
                    state_d = RUN;
                    rdy_d   = 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
        // A re-sequence request from any state parks everything in HOLD.
        if (i_soft_rst) begin
            state_d = HOLD;
            cnt_d   = '0;
            rst_d   = '1;
            rdy_d   = 1'b0;
        end
    end

    // State and output registers; i_rst overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            rst_q   <= '1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            rdy_q   <= rdy_d;
        end
    end

    // Count only while running; clear on the edge that leaves RUN.
    rst_seq_heartbeat #(.HB_DIV(HB_DIV)) u_hb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (state_q == RUN),
        .i_clr (state_d != RUN),
        .o_led (o_led)
    );

    assign o_rst   = rst_q;
    assign o_ready = rdy_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench: main config (3,8,4,5) and corner config (1,1,1,5) side by side,
// checked against a timeline model derived from the release formulas.
module tb_rst_sequencer;

    localparam int SA = 3, STA = 8, GA = 4, HBA = 5;
    localparam int SB = 1, STB = 1, GB = 1, HBB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, soft_a, rst_b, soft_b;
    logic [SA-1:0] o_rst_a;
    logic [SB-1:0] o_rst_b;
    logic          o_ready_a, o_led_a, o_ready_b, o_led_b;

    int checks = 0;
    int fails  = 0;

    // Model state: in HOLD, or cycles elapsed since edge t = 0.
    bit hold_a = 1'b1, hold_b = 1'b1;
    int t_a = 0, t_b = 0;

    rst_sequencer #(.STAGES(SA), .STRETCH_CYCLES(STA), .STAGE_GAP(GA), .HB_DIV(HBA)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_soft_rst(soft_a),
        .o_rst(o_rst_a), .o_ready(o_ready_a), .o_led(o_led_a));

    rst_sequencer #(.STAGES(SB), .STRETCH_CYCLES(STB), .STAGE_GAP(GB), .HB_DIV(HBB)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_soft_rst(soft_b),
        .o_rst(o_rst_b), .o_ready(o_ready_b), .o_led(o_led_b));

    // Expected {rst[7:0], ready, led} for a given point on the timeline.
    function automatic logic [9:0] model(input bit hold, input int t, input int stages,
                                         input int stretch, input int gap, input int hb);
        logic [9:0] r;
        int run_at;
        r = '0;
        run_at = stretch + (stages - 1) * gap + 1;
        for (int k = 0; k < stages; k++)
            r[2+k] = hold ? 1'b1 : (t < stretch + k * gap);
        if (!hold && t >= run_at) begin
            r[1] = 1'b1;
            r[0] = (((t - run_at) / hb) % 2) == 1;
        end
        return r;
    endfunction

    wire [9:0] obs_a = {5'd0, o_rst_a, o_ready_a, o_led_a};
    wire [9:0] obs_b = {7'd0, o_rst_b, o_ready_b, o_led_b};
    wire [9:0] exp_a = model(hold_a, t_a, SA, STA, GA, HBA);
    wire [9:0] exp_b = model(hold_b, t_b, SB, STB, GB, HBB);

    // One clock: advance the model with the sampled inputs, then settle.
    task automatic step();
        @(posedge clk);
        if (rst_a || soft_a) begin hold_a = 1'b1; t_a = 0; end
        else if (hold_a) begin hold_a = 1'b0; t_a = 0; end
        else t_a++;
        if (rst_b || soft_b) begin hold_b = 1'b1; t_b = 0; end
        else if (hold_b) begin hold_b = 1'b0; t_b = 0; end
        else t_b++;
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1; soft_a = 0; rst_b = 1; soft_b = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs_a !== 10'b00000_111_00) begin
                fails++; $display("FAIL reset_a got %b exp %b", obs_a, 10'b00000_111_00);
            end
            checks++;
            if (obs_b !== 10'b0000000_1_00) begin
                fails++; $display("FAIL reset_b got %b exp %b", obs_b, 10'b0000000_1_00);
            end
        end
        rst_a = 0; rst_b = 0;
        for (int tt = 0; tt <= 22; tt++) begin
            logic [3:0] want;
            step();
            want = 4'hf;
            case (tt)
                7:  want = 4'b111_0;
                8:  want = 4'b110_0;
                12: want = 4'b100_0;
                16: want = 4'b000_0;
                17: want = 4'b000_1;
                default: want = 4'hf;
            endcase
            if (want != 4'hf) begin
                checks++;
                if ({o_rst_a, o_ready_a} !== want) begin
                    fails++; $display("FAIL release_a t=%0d got %b exp %b", tt, {o_rst_a, o_ready_a}, want);
                end
            end
            if (tt <= 2) begin
                want = (tt == 0) ? 4'b0010 : (tt == 1) ? 4'b0000 : 4'b0001;
                checks++;
                if ({2'b00, o_rst_b, o_ready_b} !== want) begin
                    fails++; $display("FAIL release_b t=%0d got %b exp %b", tt, {o_rst_b, o_ready_b}, want);
                end
            end
            checks++;
            if (obs_a !== exp_a) begin
                fails++; $display("FAIL seq_a t=%0d got %b exp %b", tt, obs_a, exp_a);
            end
        end
    endtask

    task automatic test_mid_reset();
        rst_a = 1; step(); rst_a = 0;
        for (int tt = 0; tt <= 10; tt++) step();
        checks++;
        if (o_rst_a !== 3'b110) begin
            fails++; $display("FAIL mid_pre got %b exp 110", o_rst_a);
        end
        rst_a = 1; step(); rst_a = 0;
        checks++;
        if ({o_rst_a, o_ready_a} !== 4'b1110) begin
            fails++; $display("FAIL mid_hold got %b exp 1110", {o_rst_a, o_ready_a});
        end
        for (int tt = 0; tt <= 20; tt++) begin
            step();
            checks++;
            if (obs_a !== exp_a) begin
                fails++; $display("FAIL mid_seq t=%0d got %b exp %b", tt, obs_a, exp_a);
            end
        end
    endtask

    task automatic test_soft_rst();
        soft_a = 1; step(); soft_a = 0;
        checks++;
        if (obs_a !== 10'b00000_111_00) begin
            fails++; $display("FAIL soft_hold got %b exp %b", obs_a, 10'b00000_111_00);
        end
        for (int tt = 0; tt <= 20; tt++) begin
            step();
            checks++;
            if (obs_a !== exp_a) begin
                fails++; $display("FAIL soft_seq t=%0d got %b exp %b", tt, obs_a, exp_a);
            end
        end
    endtask

    task automatic test_heartbeat();
        rst_a = 1; step(); rst_a = 0;
        for (int tt = 0; tt <= 33; tt++) begin
            step();
            if (tt == 21 || tt == 22 || tt == 27 || tt == 32) begin
                checks++;
                if (o_led_a !== (tt == 22 || tt == 32)) begin
                    fails++; $display("FAIL hb_led t=%0d got %b exp %b", tt, o_led_a, (tt == 22 || tt == 32));
                end
            end
            checks++;
            if (obs_a !== exp_a) begin
                fails++; $display("FAIL hb_seq t=%0d got %b exp %b", tt, obs_a, exp_a);
            end
        end
        soft_a = 1; step(); soft_a = 0;
        checks++;
        if ({o_ready_a, o_led_a} !== 2'b00) begin
            fails++; $display("FAIL hb_clear got %b exp 00", {o_ready_a, o_led_a});
        end
    endtask

    task automatic test_both();
        rst_a = 1; soft_a = 1;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) rst_a = 0;
            step();
            checks++;
            if (obs_a !== 10'b00000_111_00) begin
                fails++; $display("FAIL both_hold i=%0d got %b exp %b", i, obs_a, 10'b00000_111_00);
            end
        end
        soft_a = 0;
        for (int tt = 0; tt <= 20; tt++) begin
            step();
            if (tt == 7 || tt == 8) begin
                checks++;
                if (o_rst_a !== ((tt == 7) ? 3'b111 : 3'b110)) begin
                    fails++; $display("FAIL both_rel t=%0d got %b", tt, o_rst_a);
                end
            end
            checks++;
            if (obs_a !== exp_a) begin
                fails++; $display("FAIL both_seq t=%0d got %b exp %b", tt, obs_a, exp_a);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst_a  = ($urandom_range(0, 199) < 2);
            soft_a = ($urandom_range(0, 199) < 3);
            rst_b  = ($urandom_range(0, 99) < 3);
            soft_b = ($urandom_range(0, 99) < 3);
            step();
            checks++;
            if (obs_a !== exp_a) begin
                fails++; $display("FAIL rand_a i=%0d got %b exp %b", i, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                fails++; $display("FAIL rand_b i=%0d got %b exp %b", i, obs_b, exp_b);
            end
        end
        rst_a = 0; soft_a = 0; rst_b = 0; soft_b = 0;
    endtask

    initial begin
        rst_a = 1; soft_a = 0; rst_b = 1; soft_b = 0;
        test_reset();
        test_mid_reset();
        test_soft_rst();
        test_heartbeat();
        test_both();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
